// File: rtl/dmem_mmio_responder.sv
// Data-memory responder: byte-lane RAM, sign/zero-extended loads and an MMIO window
// (tohost, console TX FIFO, status, mtime, error). Define DMEM_MTIME_EN to build the mtime counter.
module dmem_mmio_responder #(
    parameter int unsigned RAM_DEPTH = 1024,
    parameter logic [63:0] MMIO_BASE = 64'h0000_0000_1000_0000,
    parameter int unsigned TX_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    output logic [63:0] rdata,
    input  logic        we,
    input  logic [2:0]  size,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        halt_req,
    output logic [31:0] exit_code,
    output logic        err_misalign,
    output logic        err_overflow
);

    localparam int unsigned AW = $clog2(RAM_DEPTH);
    localparam int unsigned PW = $clog2(TX_DEPTH);
    localparam int unsigned CW = PW + 1;

    localparam logic [2:0] OFF_TOHOST = 3'd0;
    localparam logic [2:0] OFF_TX     = 3'd1;
    localparam logic [2:0] OFF_STATUS = 3'd2;
    localparam logic [2:0] OFF_MTIME  = 3'd3;
    localparam logic [2:0] OFF_ERR    = 3'd4;

    logic [63:0]   mem [RAM_DEPTH];
    logic [7:0]    fifo_mem [TX_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic          in_ram;
    logic          in_mmio;
    logic [2:0]    mmio_off;
    logic [AW-1:0] ram_idx;
    logic [2:0]    align_mask;
    logic [7:0]    size_mask;
    logic [7:0]    lane_mask;
    logic          misalign;
    logic [63:0]   wdata_sh;
    logic [63:0]   ram_sh;
    logic [63:0]   ram_ext;
    logic [63:0]   mtime_rd;
    logic          sel_tohost;
    logic          sel_tx;
    logic          sel_err;
    logic          wr_ram;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;
    logic          push_req;
    logic          push;
    logic          overflow;
    logic          tohost_set;

    // Address decode: RAM occupies the low bytes, MMIO a 64-byte window.
    assign in_ram   = (addr[63:3] < 61'(RAM_DEPTH));
    assign in_mmio  = (addr[63:6] == MMIO_BASE[63:6]);
    assign mmio_off = addr[5:3];
    assign ram_idx  = addr[AW+2:3];

    always_comb begin
        align_mask = 3'b000;
        size_mask  = 8'h01;
        case (size[1:0])
            2'd0: begin align_mask = 3'b000; size_mask = 8'h01; end
            2'd1: begin align_mask = 3'b001; size_mask = 8'h03; end
            2'd2: begin align_mask = 3'b011; size_mask = 8'h0F; end
            default: begin align_mask = 3'b111; size_mask = 8'hFF; end
        endcase
    end

    // MMIO registers only accept naturally aligned doubleword accesses.
    assign misalign = (in_ram && ((addr[2:0] & align_mask) != 3'd0)) ||
                      (in_mmio && ((size[1:0] != 2'd3) || (addr[2:0] != 3'd0)));

    assign lane_mask  = size_mask << addr[2:0];
    assign wdata_sh   = wdata << {addr[2:0], 3'b000};
    assign wr_ram     = we && in_ram && !misalign;
    assign sel_tohost = in_mmio && !misalign && (mmio_off == OFF_TOHOST);
    assign sel_tx     = in_mmio && !misalign && (mmio_off == OFF_TX);
    assign sel_err    = in_mmio && !misalign && (mmio_off == OFF_ERR);

    // Load path: shift the addressed lanes down, then extend per size.
    assign ram_sh = mem[ram_idx] >> {addr[2:0], 3'b000};

    always_comb begin
        ram_ext = ram_sh;
        case (size[1:0])
            2'd0: ram_ext = {{56{~size[2] & ram_sh[7]}},  ram_sh[7:0]};
            2'd1: ram_ext = {{48{~size[2] & ram_sh[15]}}, ram_sh[15:0]};
            2'd2: ram_ext = {{32{~size[2] & ram_sh[31]}}, ram_sh[31:0]};
            default: ram_ext = ram_sh;
        endcase
    end

    always_comb begin
        rdata = 64'd0;
        if (misalign) begin
            rdata = 64'd0;
        end else if (in_ram) begin
            rdata = ram_ext;
        end else if (in_mmio) begin
            case (mmio_off)
                OFF_TOHOST: rdata = {32'd0, exit_code};
                OFF_STATUS: rdata = {16'd0, 16'(count), 30'd0, fifo_full, fifo_empty};
                OFF_MTIME:  rdata = mtime_rd;
                OFF_ERR:    rdata = {62'd0, err_overflow, err_misalign};
                default:    rdata = 64'd0;
            endcase
        end
    end

    // RAM contents survive reset, so the array has no reset branch.
    always_ff @(posedge clk) begin
        if (wr_ram) begin
            for (int b = 0; b < 8; b++) begin
                if (lane_mask[b]) begin
                    mem[ram_idx][b*8 +: 8] <= wdata_sh[b*8 +: 8];
                end
            end
        end
    end

    assign fifo_full  = (count == CW'(TX_DEPTH));
    assign fifo_empty = (count == CW'(0));
    assign tx_valid   = !fifo_empty;
    assign tx_data    = fifo_empty ? 8'd0 : fifo_mem[rd_ptr];
    assign pop        = tx_valid && tx_ready;
    assign push_req   = we && sel_tx;
    // A same-cycle pop frees a slot, so a push into a full FIFO still lands.
    assign push       = push_req && (!fifo_full || pop);
    assign overflow   = push_req && !push;
    assign tohost_set = we && sel_tohost && !halt_req && (wdata != 64'd0);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= wdata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            halt_req  <= 1'b0;
            exit_code <= 32'd0;
        end else if (tohost_set) begin
            halt_req  <= 1'b1;
            exit_code <= wdata[31:0];
        end
    end

    // A new error in the same cycle as an ERR write keeps the flag set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_misalign <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            if (misalign)                 err_misalign <= 1'b1;
            else if (we && sel_err)       err_misalign <= 1'b0;
            if (overflow)                 err_overflow <= 1'b1;
            else if (we && sel_err)       err_overflow <= 1'b0;
        end
    end

`ifdef DMEM_MTIME_EN
    logic [63:0] mtime;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mtime <= 64'd0;
        end else begin
            mtime <= mtime + 64'd1;
        end
    end

    assign mtime_rd = mtime;
`else
    assign mtime_rd = 64'd0;
`endif

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Directed bench for dmem_mmio_responder: loads/stores, misalign, TX FIFO, tohost, mtime.
module tb_dmem_mmio_responder;

    localparam logic [63:0] MB        = 64'h0000_0000_1000_0000;
    localparam logic [63:0] A_TOHOST  = MB;
    localparam logic [63:0] A_TX      = MB + 64'h08;
    localparam logic [63:0] A_STATUS  = MB + 64'h10;
    localparam logic [63:0] A_MTIME   = MB + 64'h18;
    localparam logic [63:0] A_ERR     = MB + 64'h20;
    localparam logic [63:0] IDLE_ADDR = 64'h100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] addr = IDLE_ADDR;
    logic [63:0] wdata = 64'd0;
    logic [63:0] rdata;
    logic        we = 1'b0;
    logic [2:0]  size = 3'd3;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b0;
    logic        halt_req;
    logic [31:0] exit_code;
    logic        err_misalign;
    logic        err_overflow;

    int total = 0;
    int bad = 0;

    dmem_mmio_responder dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .rdata(rdata),
        .we(we), .size(size), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(tx_ready), .halt_req(halt_req), .exit_code(exit_code),
        .err_misalign(err_misalign), .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic st(input logic [63:0] a, input logic [63:0] d, input logic [2:0] sz);
        addr = a; wdata = d; size = sz; we = 1'b1;
        cyc();
        we = 1'b0; addr = IDLE_ADDR; size = 3'd3;
    endtask

    task automatic ld(input logic [63:0] a, input logic [2:0] sz, output logic [63:0] v);
        addr = a; size = sz; we = 1'b0;
        #1;
        v = rdata;
        addr = IDLE_ADDR; size = 3'd3;
    endtask

    task automatic test_reset();
        logic [63:0] v;
        rst_n = 1'b0;
        cyc(); cyc();
        rst_n = 1'b1;
        total++; if ({tx_valid, tx_data, halt_req, err_misalign, err_overflow} !== 12'd0) begin
            bad++; $display("FAIL reset_flags got=%h exp=0", {tx_valid, tx_data, halt_req, err_misalign, err_overflow});
        end
        total++; if (exit_code !== 32'd0) begin
            bad++; $display("FAIL reset_exit got=%h exp=0", exit_code);
        end
        ld(A_STATUS, 3'd3, v);
        total++; if (v !== 64'h1) begin
            bad++; $display("FAIL reset_status got=%h exp=%h", v, 64'h1);
        end
    endtask

    task automatic test_loads();
        logic [63:0] v;
        st(64'h100, 64'h8877665544332211, 3'd3);
        ld(64'h107, 3'd0, v);
        total++; if (v !== 64'hFFFF_FFFF_FFFF_FF88) begin bad++; $display("FAIL lb got=%h exp=%h", v, 64'hFFFF_FFFF_FFFF_FF88); end
        ld(64'h107, 3'd4, v);
        total++; if (v !== 64'h88) begin bad++; $display("FAIL lbu got=%h exp=%h", v, 64'h88); end
        ld(64'h102, 3'd1, v);
        total++; if (v !== 64'h4433) begin bad++; $display("FAIL lh got=%h exp=%h", v, 64'h4433); end
        ld(64'h106, 3'd5, v);
        total++; if (v !== 64'h8877) begin bad++; $display("FAIL lhu got=%h exp=%h", v, 64'h8877); end
        ld(64'h104, 3'd2, v);
        total++; if (v !== 64'hFFFF_FFFF_8877_6655) begin bad++; $display("FAIL lw got=%h exp=%h", v, 64'hFFFF_FFFF_8877_6655); end
        ld(64'h104, 3'd6, v);
        total++; if (v !== 64'h8877_6655) begin bad++; $display("FAIL lwu got=%h exp=%h", v, 64'h8877_6655); end
        ld(64'h100, 3'd3, v);
        total++; if (v !== 64'h8877665544332211) begin bad++; $display("FAIL ld got=%h exp=%h", v, 64'h8877665544332211); end
    endtask

    task automatic test_stores();
        logic [63:0] v;
        // Store byte with junk above the low byte; read-before-edge sees old data.
        addr = 64'h101; wdata = 64'hFFFF_FFFF_FFFF_FFAA; size = 3'd0; we = 1'b1;
        #1;
        total++; if (rdata !== 64'h22) begin bad++; $display("FAIL old_before_edge got=%h exp=%h", rdata, 64'h22); end
        cyc();
        we = 1'b0; addr = IDLE_ADDR; size = 3'd3;
        ld(64'h100, 3'd3, v);
        total++; if (v !== 64'h887766554433AA11) begin bad++; $display("FAIL sb_merge got=%h exp=%h", v, 64'h887766554433AA11); end
        // Misaligned halfword: read 0, store dropped, flag sticky.
        addr = 64'h103; wdata = 64'h5555; size = 3'd1; we = 1'b1;
        #1;
        total++; if (rdata !== 64'd0) begin bad++; $display("FAIL misalign_read got=%h exp=0", rdata); end
        cyc();
        we = 1'b0; addr = IDLE_ADDR; size = 3'd3;
        total++; if (err_misalign !== 1'b1) begin bad++; $display("FAIL misalign_flag got=%b exp=1", err_misalign); end
        ld(64'h100, 3'd3, v);
        total++; if (v !== 64'h887766554433AA11) begin bad++; $display("FAIL misalign_drop got=%h exp=%h", v, 64'h887766554433AA11); end
        ld(A_ERR, 3'd3, v);
        total++; if (v !== 64'h1) begin bad++; $display("FAIL err_read got=%h exp=1", v); end
        st(A_ERR, 64'd0, 3'd3);
        total++; if (err_misalign !== 1'b0) begin bad++; $display("FAIL err_clear got=%b exp=0", err_misalign); end
        // Unmapped: store ignored, read 0, no error.
        st(64'h4000_0000, 64'h1234, 3'd3);
        ld(64'h4000_0000, 3'd3, v);
        total++; if (v !== 64'd0 || err_misalign !== 1'b0) begin
            bad++; $display("FAIL unmapped got=%h/%b exp=0/0", v, err_misalign);
        end
    endtask

    task automatic test_tx();
        logic [63:0] v;
        tx_ready = 1'b0;
        addr = A_TX; wdata = 64'h48; size = 3'd3; we = 1'b1;
        #1;
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL tx_valid_early got=%b exp=0", tx_valid); end
        cyc();
        we = 1'b0; addr = IDLE_ADDR;
        total++; if (tx_valid !== 1'b1) begin bad++; $display("FAIL tx_valid_after got=%b exp=1", tx_valid); end
        st(A_TX, 64'h69, 3'd3);
        ld(A_STATUS, 3'd3, v);
        total++; if (v !== 64'h0000_0002_0000_0000) begin bad++; $display("FAIL status_2 got=%h exp=%h", v, 64'h0000_0002_0000_0000); end
        total++; if (tx_data !== 8'h48) begin bad++; $display("FAIL tx_head got=%h exp=48", tx_data); end
        tx_ready = 1'b1;
        cyc();
        total++; if (tx_valid !== 1'b1 || tx_data !== 8'h69) begin bad++; $display("FAIL tx_second got=%b/%h exp=1/69", tx_valid, tx_data); end
        cyc();
        total++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin bad++; $display("FAIL tx_drained got=%b/%h exp=0/00", tx_valid, tx_data); end
        tx_ready = 1'b0;
    endtask

    task automatic test_overflow();
        logic [63:0] v;
        tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) st(A_TX, 64'(8'h10 + i), 3'd3);
        ld(A_STATUS, 3'd3, v);
        total++; if (v !== 64'h0000_0008_0000_0002) begin bad++; $display("FAIL status_full got=%h exp=%h", v, 64'h0000_0008_0000_0002); end
        total++; if (err_overflow !== 1'b1) begin bad++; $display("FAIL overflow_flag got=%b exp=1", err_overflow); end
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            total++; if (tx_valid !== 1'b1 || tx_data !== 8'(8'h10 + i)) begin
                bad++; $display("FAIL drain_%0d got=%b/%h exp=1/%h", i, tx_valid, tx_data, 8'(8'h10 + i));
            end
            cyc();
        end
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL drain_empty got=%b exp=0", tx_valid); end
        tx_ready = 1'b0;
        st(A_ERR, 64'd0, 3'd3);
        total++; if (err_overflow !== 1'b0) begin bad++; $display("FAIL overflow_clear got=%b exp=0", err_overflow); end
        // Full FIFO with a same-cycle pop accepts the push.
        for (int i = 0; i < 8; i++) st(A_TX, 64'(8'h20 + i), 3'd3);
        tx_ready = 1'b1;
        st(A_TX, 64'h28, 3'd3);
        tx_ready = 1'b0;
        total++; if (err_overflow !== 1'b0) begin bad++; $display("FAIL push_pop_full_err got=%b exp=0", err_overflow); end
        ld(A_STATUS, 3'd3, v);
        total++; if (v !== 64'h0000_0008_0000_0002) begin bad++; $display("FAIL push_pop_count got=%h exp=%h", v, 64'h0000_0008_0000_0002); end
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            total++; if (tx_data !== 8'(8'h21 + i)) begin
                bad++; $display("FAIL drain2_%0d got=%h exp=%h", i, tx_data, 8'(8'h21 + i));
            end
            cyc();
        end
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL drain2_empty got=%b exp=0", tx_valid); end
        tx_ready = 1'b0;
    endtask

    task automatic test_halt();
        logic [63:0] v;
        st(A_TOHOST, 64'd0, 3'd3);
        total++; if (halt_req !== 1'b0) begin bad++; $display("FAIL halt_zero got=%b exp=0", halt_req); end
        addr = A_TOHOST; wdata = 64'h2A; size = 3'd3; we = 1'b1;
        #1;
        total++; if (halt_req !== 1'b0) begin bad++; $display("FAIL halt_early got=%b exp=0", halt_req); end
        cyc();
        we = 1'b0; addr = IDLE_ADDR;
        total++; if (halt_req !== 1'b1 || exit_code !== 32'h2A) begin bad++; $display("FAIL halt_set got=%b/%h exp=1/2a", halt_req, exit_code); end
        st(A_TOHOST, 64'h5, 3'd3);
        total++; if (exit_code !== 32'h2A) begin bad++; $display("FAIL exit_sticky got=%h exp=2a", exit_code); end
        ld(A_TOHOST, 3'd3, v);
        total++; if (v !== 64'h2A) begin bad++; $display("FAIL tohost_read got=%h exp=2a", v); end
        st(A_TX, 64'h77, 3'd3);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        total++; if (halt_req !== 1'b0 || exit_code !== 32'd0 || tx_valid !== 1'b0) begin
            bad++; $display("FAIL mid_reset got=%b/%h/%b exp=0/0/0", halt_req, exit_code, tx_valid);
        end
        ld(64'h100, 3'd3, v);
        total++; if (v !== 64'h887766554433AA11) begin bad++; $display("FAIL ram_kept got=%h exp=%h", v, 64'h887766554433AA11); end
    endtask

    task automatic test_mtime();
        logic [63:0] v1;
        logic [63:0] v2;
        cyc();
        ld(A_MTIME, 3'd3, v1);
        repeat (5) cyc();
        ld(A_MTIME, 3'd3, v2);
`ifdef DMEM_MTIME_EN
        total++; if (v2 - v1 !== 64'd5) begin bad++; $display("FAIL mtime_delta got=%0d exp=5", v2 - v1); end
        total++; if (v1 === 64'd0) begin bad++; $display("FAIL mtime_running got=%h exp=nonzero", v1); end
`else
        total++; if (v1 !== 64'd0 || v2 !== 64'd0) begin bad++; $display("FAIL mtime_zero got=%h/%h exp=0/0", v1, v2); end
`endif
    endtask

    initial begin
        test_reset();
        test_loads();
        test_stores();
        test_tx();
        test_overflow();
        test_halt();
        test_mtime();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
